// File: rtl/niosii_input_pio_capture.sv
// niosii_input_pio_capture: Avalon-MM input PIO with a synchronizer on
// in_port_i, per-bit rise/fall edge capture and a maskable level irq.
//
// Ports:
//   clk_i         system clock, all logic on the rising edge
//   reset_n_i     synchronous active-low reset
//   address_i     word address (0 DATA, 1 EDGE_EN, 2 IRQ_MASK, 3 CAPTURE)
//   chipselect_i  slave select
//   read_n_i      active-low read strobe
//   write_n_i     active-low write strobe
//   writedata_i   write data
//   in_port_i     asynchronous external input bus
//   readdata_o    registered read data, latency 1, held between reads
//   irq_o         registered active-high level interrupt
module niosii_input_pio_capture #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [1:0]       address_i,
   input  logic             chipselect_i,
   input  logic             read_n_i,
   input  logic             write_n_i,
   input  logic [31:0]      writedata_i,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [31:0]      readdata_o,
   output logic             irq_o
);

   // The fall-enable field lives at [WIDTH+15:16]; it cannot extend past
   // bit 31, so for WIDTH > 16 only the low 16 bits have a fall enable.
   localparam int unsigned FW = (WIDTH > 16) ? 16 : WIDTH;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_EDGE = 2'd1;
   localparam logic [1:0] A_MASK = 2'd2;
   localparam logic [1:0] A_CAP  = 2'd3;

   // Synchronizer: stage 0 samples in_port_i, the last stage is "sync".
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
   logic [WIDTH-1:0]                  sync_w;
   logic [WIDTH-1:0]                  prev_q;

   // Software-visible registers.
   logic [WIDTH-1:0] rise_en_q;
   logic [WIDTH-1:0] rise_en_d;
   logic [FW-1:0]    fall_en_q;
   logic [FW-1:0]    fall_en_d;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [31:0]      readdata_q;
   logic [31:0]      readdata_d;
   logic             irq_q;
   logic             irq_d;

   // Bus decode and datapath helpers.
   logic             wr;
   logic             rd;
   logic             wr_edge;
   logic             wr_mask;
   logic             wr_cap;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] fall_en_w;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [31:0]      rd_word;
   logic             unused_wd;

   assign wr      = chipselect_i & ~write_n_i;
   assign rd      = chipselect_i & ~read_n_i;
   assign wr_edge = wr && (address_i == A_EDGE);
   assign wr_mask = wr && (address_i == A_MASK);
   assign wr_cap  = wr && (address_i == A_CAP);

   assign sync_w = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], in_port_i};

   // Writedata bits outside the register fields are intentionally ignored.
   assign unused_wd = ^writedata_i;

   // Edge detection on the synchronized value against its previous sample.
   always_comb begin
      fall_en_w         = '0;
      fall_en_w[FW-1:0] = fall_en_q;
      rise              = sync_w & ~prev_q & rise_en_q;
      fall              = ~sync_w & prev_q & fall_en_w;
   end

   // Register next-state. Clearing is applied before OR-ing in new edges so
   // an edge landing in the same cycle as its clear is never lost.
   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      mask_d    = mask_q;
      clr       = '0;
      if (wr_edge) begin
         rise_en_d = writedata_i[WIDTH-1:0];
         fall_en_d = writedata_i[FW+15:16];
      end
      if (wr_mask) begin
         mask_d = writedata_i[WIDTH-1:0];
      end
      if (wr_cap) begin
         clr = writedata_i[WIDTH-1:0];
      end
      cap_d = (cap_q & ~clr) | rise | fall;
      irq_d = |(cap_q & mask_q);
   end

   // Read mux sees pre-write register values, so a simultaneous read and
   // write returns the old contents.
   always_comb begin
      rd_word = '0;
      unique case (address_i)
         A_DATA: rd_word[WIDTH-1:0] = sync_w;
         A_EDGE: begin
            rd_word[WIDTH-1:0] = rise_en_q;
            rd_word[FW+15:16]  = fall_en_q;
         end
         A_MASK: rd_word[WIDTH-1:0] = mask_q;
         A_CAP:  rd_word[WIDTH-1:0] = cap_q;
         default: rd_word = '0;
      endcase
      readdata_d = rd ? rd_word : readdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         sync_q     <= '0;
         prev_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= sync_w;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata_o = readdata_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_niosii_input_pio_capture.sv
// tb_niosii_input_pio_capture: directed scenario bench for the input PIO.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_niosii_input_pio_capture;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SS    = 2;

   logic             clk;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [31:0]      writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0]      readdata;
   logic             irq;

   int tests;
   int fails;

   niosii_input_pio_capture #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SS)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .address_i(address),
      .chipselect_i(chipselect),
      .read_n_i(read_n),
      .write_n_i(write_n),
      .writedata_i(writedata),
      .in_port_i(in_port),
      .readdata_o(readdata),
      .irq_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = a;
      tick(1);
      d          = readdata;
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset_n = 1'b0;
      in_port = 8'hFF;
      tick(3);
      tests++;
      if (readdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0);
      end
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      reset_n = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         bus_read(2'(a), d);
         tests++;
         if (d !== 32'h0) begin
            fails++;
            $display("FAIL reset_reg%0d: got %h want %h", a, d, 32'h0);
         end
      end
      bus_read(2'd0, d);
      tests++;
      if (d !== 32'h0000_00FF) begin
         fails++;
         $display("FAIL reset_data: got %h want %h", d, 32'hFF);
      end
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL reset_no_cap: got %h want %h", d, 32'h0);
      end
   endtask

   task automatic test_rise;
      logic [31:0] d;
      int          lat;
      in_port = 8'h00;
      tick(4);
      bus_write(2'd1, 32'h0000_0001);
      bus_write(2'd2, 32'h0000_0001);
      tick(2);
      in_port = 8'h01;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         tick(1);
         if (irq === 1'b1 && lat == 0) lat = n;
      end
      tests++;
      if (lat != SS + 2) begin
         fails++;
         $display("FAIL rise_irq_latency: got %0d want %0d", lat, SS + 2);
      end
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h01) begin
         fails++;
         $display("FAIL rise_cap: got %h want %h", d, 32'h01);
      end
      in_port = 8'h00;
      tick(5);
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h01 || irq !== 1'b1) begin
         fails++;
         $display("FAIL rise_fall_ignored: got cap %h irq %b want 01 1",
                  d, irq);
      end
      bus_write(2'd3, 32'h0000_0001);
      tick(2);
   endtask

   task automatic test_fall_both;
      logic [31:0] d;
      bus_write(2'd1, 32'h0080_0080);
      bus_write(2'd2, 32'h0000_0081);
      in_port = 8'h80;
      tick(3);
      bus_read(2'd3, d);
      in_port = 8'h00;
      tests++;
      if (d !== 32'h80) begin
         fails++;
         $display("FAIL both_after_rise: got %h want %h", d, 32'h80);
      end
      tick(5);
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h80 || irq !== 1'b1) begin
         fails++;
         $display("FAIL both_after_fall: got cap %h irq %b want 80 1",
                  d, irq);
      end
      bus_write(2'd3, 32'h0000_0080);
      tick(1);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL both_clr_irq: got %b want 0", irq);
      end
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL both_clr_cap: got %h want %h", d, 32'h0);
      end
   endtask

   task automatic test_collision;
      logic [31:0] d;
      bus_write(2'd1, 32'h0000_0001);
      bus_write(2'd2, 32'h0000_0001);
      tick(2);
      in_port = 8'h01;
      tick(2);
      // rise for bit0 is live during the cycle ending at this write edge
      bus_write(2'd3, 32'h0000_0001);
      tick(1);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL coll_irq: got %b want 1", irq);
      end
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h01) begin
         fails++;
         $display("FAIL coll_cap: got %h want %h", d, 32'h01);
      end
      in_port = 8'h00;
      bus_write(2'd2, 32'h0);
      tick(3);
      bus_write(2'd3, 32'h0000_00FF);
      tick(2);
   endtask

   task automatic test_mask;
      logic [31:0] d;
      bus_write(2'd1, 32'h0000_0005);
      in_port = 8'h05;
      tick(5);
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h05 || irq !== 1'b0) begin
         fails++;
         $display("FAIL mask_off: got cap %h irq %b want 05 0", d, irq);
      end
      bus_write(2'd2, 32'h0000_0004);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL mask_at_write: got %b want 0", irq);
      end
      tick(1);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL mask_on: got %b want 1", irq);
      end
      bus_write(2'd3, 32'h0000_0004);
      tick(1);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL mask_clr_irq: got %b want 0", irq);
      end
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h01) begin
         fails++;
         $display("FAIL mask_clr_cap: got %h want %h", d, 32'h01);
      end
   endtask

   task automatic test_regs;
      logic [31:0] d;
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd1, d);
      tests++;
      if (d !== 32'h00FF_00FF) begin
         fails++;
         $display("FAIL reg_edge_en: got %h want %h", d, 32'h00FF00FF);
      end
      bus_write(2'd0, 32'h0000_00AA);
      bus_read(2'd0, d);
      tests++;
      if (d !== 32'h05) begin
         fails++;
         $display("FAIL reg_data_ro: got %h want %h", d, 32'h05);
      end
      tick(3);
      tests++;
      if (readdata !== 32'h05) begin
         fails++;
         $display("FAIL reg_hold: got %h want %h", readdata, 32'h05);
      end
      chipselect = 1'b1;
      read_n     = 1'b0;
      write_n    = 1'b0;
      address    = 2'd2;
      writedata  = 32'hFFFF_FF3C;
      tick(1);
      d          = readdata;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      tests++;
      if (d !== 32'h04) begin
         fails++;
         $display("FAIL reg_rw_old: got %h want %h", d, 32'h04);
      end
      bus_read(2'd2, d);
      tests++;
      if (d !== 32'h3C) begin
         fails++;
         $display("FAIL reg_rw_new: got %h want %h", d, 32'h3C);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(3);
      bus_read(2'd3, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++;
         $display("FAIL midrst_cap: got cap %h irq %b want 0 0", d, irq);
      end
      bus_read(2'd2, d);
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL midrst_mask: got %h want %h", d, 32'h0);
      end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = '0;
      tick(1);
      test_reset;
      test_rise;
      test_fall_both;
      test_collision;
      test_mask;
      test_regs;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
